// File: rtl/tl_pkg.sv
// tl_pkg: shared types and constants for the intersection phase scheduler.
//   phase_e  : controller phase, encoded ALLRED=0, GREEN=1, YELLOW=2
//   LAMP_W   : width of one approach's lamp field
//   LAMP_*   : one-hot lamp codes (red / yellow / green)
//   lamp_for : lamp code for one approach given the phase and ownership
package tl_pkg;

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

  // Approaches that do not own the intersection are always red; the owner
  // shows green or yellow, and nobody is lit in all-red.
  function automatic logic [LAMP_W-1:0] lamp_for(input phase_e ph, input logic own);
    logic [LAMP_W-1:0] lamp;
    lamp = LAMP_RED;
    if (own) begin
      case (ph)
        PH_GREEN:  lamp = LAMP_GRN;
        PH_YELLOW: lamp = LAMP_YEL;
        default:   lamp = LAMP_RED;
      endcase
    end else begin
      lamp = LAMP_RED;
    end
    return lamp;
  endfunction

endpackage

// File: rtl/tl_rr_pick.sv
// tl_rr_pick: combinational round-robin picker.
//   req       in  N_APPR : level requests
//   cur_idx   in  IDX_W  : current owner (excluded from the search)
//   nxt       out IDX_W  : first requester after cur_idx, wrapping; cur_idx if none
//   any_other out 1      : some approach other than cur_idx is requesting
module tl_rr_pick #(
  parameter int unsigned N_APPR = 4,
  localparam int unsigned IDX_W = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
  input  logic [N_APPR-1:0] req,
  input  logic [IDX_W-1:0]  cur_idx,
  output logic [IDX_W-1:0]  nxt,
  output logic              any_other
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset back to the nearest so that the nearest
  // requester after cur_idx is the last (winning) assignment.
  always_comb begin
    nxt       = cur_idx;
    any_other = 1'b0;
    cand_s    = {IDX_W{1'b0}};
    for (int k = N_APPR - 1; k >= 1; k--) begin
      cand_s    = IDX_W'((int'(cur_idx) + k) % N_APPR);
      nxt       = req[cand_s] ? cand_s : nxt;
      any_other = any_other | req[cand_s];
    end
  end

endmodule

// File: rtl/tl_phase_scheduler.sv
// tl_phase_scheduler: N-approach signalised intersection controller.
// Grants green to one approach at a time in round-robin order, enforcing
// minimum/maximum green, yellow and all-red clearance dwell times.
//   clk         in  1         : clock, rising edge
//   rst_n       in  1         : asynchronous active-low reset
//   req         in  N_APPR    : per-approach level request
//   preempt     in  1         : (TL_PREEMPT_EN only) force service of preempt_idx
//   preempt_idx in  IDX_W     : (TL_PREEMPT_EN only) approach to preempt to
//   light       out 3*N_APPR  : lamp per approach, slice i = light[3i+2:3i]
//   cur_idx     out IDX_W     : owner (green/yellow) or target (all-red)
//   phase       out 2         : ALLRED=0, GREEN=1, YELLOW=2
// Optional feature macro: TL_PREEMPT_EN (adds the preempt ports).
module tl_phase_scheduler
  import tl_pkg::*;
#(
  parameter int unsigned N_APPR    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2,
  localparam int unsigned IDX_W    = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_APPR-1:0]          req,
`ifdef TL_PREEMPT_EN
  input  logic                       preempt,
  input  logic [IDX_W-1:0]           preempt_idx,
`endif
  output logic [LAMP_W*N_APPR-1:0]   light,
  output logic [IDX_W-1:0]           cur_idx,
  output logic [1:0]                 phase
);

  // Terminal counts are "dwell - 1" because the timer starts at 0 on entry.
  localparam logic [CNT_W-1:0] TMR_MIN = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] TMR_MAX = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] TMR_YEL = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] TMR_AR  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TMR_ONE = CNT_W'(1);

  phase_e                     state_q, state_d;
  logic [CNT_W-1:0]           tmr_q, tmr_d;
  logic [IDX_W-1:0]           cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0]           nxt_q, nxt_d;
  logic [LAMP_W*N_APPR-1:0]   light_q, light_d;

  logic [IDX_W-1:0]           pick_nxt_s;
  logic                       any_other_s;
  logic                       cur_req_s;
  logic [CNT_W-1:0]           tmr_sat_s;
  logic                       preempt_s;
  logic [IDX_W-1:0]           pidx_s;

`ifdef TL_PREEMPT_EN
  assign preempt_s = preempt;
  assign pidx_s    = preempt_idx;
`else
  assign preempt_s = 1'b0;
  assign pidx_s    = {IDX_W{1'b0}};
`endif

  tl_rr_pick #(.N_APPR(N_APPR)) u_pick (
    .req       (req),
    .cur_idx   (cur_idx_q),
    .nxt       (pick_nxt_s),
    .any_other (any_other_s)
  );

  assign cur_req_s = req[cur_idx_q];
  // Green timer stops at the max-green terminal so a long uncontested rest
  // can never wrap back below the min/max thresholds.
  assign tmr_sat_s = (tmr_q >= TMR_MAX) ? tmr_q : (tmr_q + TMR_ONE);

  // Next-state, timer, owner and committed-target logic.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cur_idx_d = cur_idx_q;
    nxt_d     = nxt_q;
    case (state_q)
      PH_ALLRED: begin
        if (preempt_s) begin
          cur_idx_d = pidx_s;
        end else begin
          cur_idx_d = cur_idx_q;
        end
        if (tmr_q == TMR_AR) begin
          state_d = PH_GREEN;
          tmr_d   = {CNT_W{1'b0}};
        end else begin
          tmr_d   = tmr_q + TMR_ONE;
        end
      end
      PH_GREEN: begin
        if (preempt_s && (cur_idx_q != pidx_s)) begin
          state_d = PH_YELLOW;
          nxt_d   = pidx_s;
          tmr_d   = {CNT_W{1'b0}};
        end else if (preempt_s) begin
          // Preempted approach already green: hold regardless of max green.
          tmr_d   = tmr_sat_s;
        end else if (any_other_s && (tmr_q >= TMR_MIN) &&
                     (!cur_req_s || (tmr_q >= TMR_MAX))) begin
          state_d = PH_YELLOW;
          nxt_d   = pick_nxt_s;
          tmr_d   = {CNT_W{1'b0}};
        end else begin
          tmr_d   = tmr_sat_s;
        end
      end
      PH_YELLOW: begin
        if (preempt_s) begin
          nxt_d = pidx_s;
        end else begin
          nxt_d = nxt_q;
        end
        if (tmr_q == TMR_YEL) begin
          state_d   = PH_ALLRED;
          cur_idx_d = nxt_d;
          tmr_d     = {CNT_W{1'b0}};
        end else begin
          tmr_d     = tmr_q + TMR_ONE;
        end
      end
      default: begin
        state_d   = PH_ALLRED;
        tmr_d     = {CNT_W{1'b0}};
        cur_idx_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Lamp decode from the next registered state so the lamps are themselves
  // flops yet change on the same edge as phase/cur_idx.
  always_comb begin
    light_d = {N_APPR{LAMP_RED}};
    for (int i = 0; i < N_APPR; i++) begin
      light_d[LAMP_W*i +: LAMP_W] = lamp_for(state_d, cur_idx_d == IDX_W'(i));
    end
  end

  // State registers; reset restarts the sequence in all-red toward approach 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PH_ALLRED;
      tmr_q     <= {CNT_W{1'b0}};
      cur_idx_q <= {IDX_W{1'b0}};
      nxt_q     <= {IDX_W{1'b0}};
      light_q   <= {N_APPR{LAMP_RED}};
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cur_idx_q <= cur_idx_d;
      nxt_q     <= nxt_d;
      light_q   <= light_d;
    end
  end

  assign light   = light_q;
  assign cur_idx = cur_idx_q;
  assign phase   = state_q;

endmodule

// File: doc/tl_phase_scheduler.md
# tl_phase_scheduler

Phase scheduler for a signalised intersection of N approaches, the controller that owns the shared intersection resource. Each approach drives a level request (vehicle sensor). The scheduler grants green to one approach at a time in round-robin order and enforces minimum green, maximum green, yellow and all-red clearance intervals. It also drives the 3-bit light for every approach. It generalises the two-road highway/farm controller to N approaches and sits directly above the per-approach lamp drivers.

## Interface
- `N_APPR`, 4: number of approaches, ≥2; approach 0 is the home approach.
- `CNT_W`, 8: phase timer width; every timing parameter must be < 2^CNT_W.
- `MIN_GREEN`, 8: minimum green dwell in cycles, ≥1.
- `MAX_GREEN`, 32: maximum green dwell when contested, ≥`MIN_GREEN`.
- `YELLOW_T`, 4: yellow dwell in cycles, ≥1.
- `ALLRED_T`, 2: all-red clearance dwell in cycles, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in `N_APPR`: level request per approach, synchronous to `clk`.
- `light` out 3·`N_APPR`: per-approach lamp, slice i = `light[3i+2:3i]`.
  - Encoding: `3'b100` red, `3'b010` yellow, `3'b001` green.
- `cur_idx` out clog2(`N_APPR`): approach currently owning the intersection (green/yellow) or targeted (all-red).
- `phase` out 2: current phase, with ALLRED=0, GREEN=1, YELLOW=2.

## Operation
- The FSM has three states: ALLRED, GREEN and YELLOW. A timer `tmr` clears to 0 on every state entry and increments each cycle in the state.
- ALLRED:
  - All lamps are red.
  - When `tmr == ALLRED_T-1`, the FSM moves to GREEN on `cur_idx`.
- GREEN:
  - The `cur_idx` lamp is green; all others are red.
  - Let `other` be OR of `req` with bit `cur_idx` masked.
  - Leave to YELLOW when `other && tmr ≥ MIN_GREEN-1 && (!req[cur_idx] || tmr ≥ MAX_GREEN-1)`.
  - Otherwise stay in GREEN, resting indefinitely if there is no contest.
  - `tmr` saturates at `MAX_GREEN-1`.
- YELLOW:
  - The `cur_idx` lamp is yellow; all others are red.
  - When `tmr == YELLOW_T-1`, the FSM moves to ALLRED and `cur_idx` loads `nxt`.
- `nxt` is latched on the GREEN→YELLOW edge.
  - Value: the first `req` bit set scanning `cur_idx+1, cur_idx+2, …` modulo `N_APPR`, excluding `cur_idx`.
  - Wrap-around: after approach `N_APPR-1` the scan continues from 0.
- The target is committed once latched. If its request drops during YELLOW/ALLRED, it still receives at least `MIN_GREEN` of green.
- Simultaneous requests are resolved by round-robin order only; there are no fixed priorities.
- Requests arriving during YELLOW/ALLRED have no effect on the committed target.
- At every cycle exactly one lamp slice is non-red, except in ALLRED, where none is.

## Timing
- Reset (async, while `rst_n`=0):
  - `phase`=ALLRED, `tmr`=0, `cur_idx`=0.
  - All `light` slices = `3'b100`.
- After reset release, approach 0 turns green after exactly `ALLRED_T` rising edges.
- Outputs are Moore: decoded from registered state, `cur_idx` and `tmr` only. There is no combinational `req`→`light` path.
- Exit decision latency: the condition evaluated in cycle k takes effect at edge k+1.
- A contested green lasts between `MIN_GREEN` and `MAX_GREEN` cycles inclusive.
- Green-to-green handover takes exactly `YELLOW_T + ALLRED_T` cycles.
- If reset is asserted mid-phase, outputs return to all-red immediately and the sequence restarts from approach 0.

## Configuration
- Macro `TL_PREEMPT_EN` adds ports `preempt` (in 1) and `preempt_idx` (in clog2(`N_APPR`)).
- With the macro defined, while `preempt`=1:
  - GREEN with `cur_idx != preempt_idx`: go to YELLOW next edge, ignoring `MIN_GREEN`; `nxt = preempt_idx`.
  - YELLOW/ALLRED: `nxt`/`cur_idx` are overridden to `preempt_idx`; clearance durations are never shortened.
  - GREEN with `cur_idx == preempt_idx`: hold green and ignore `MAX_GREEN`.
- Without the macro, the ports are absent and behaviour is as in Operation.

## Structure
- Package `tl_pkg` holds:
  - the phase enum (ALLRED/GREEN/YELLOW);
  - the lamp constants `LAMP_RED`, `LAMP_YEL`, `LAMP_GRN`;
  - the lamp field width 3.
- Sub-module `tl_rr_pick`: a combinational round-robin picker with inputs `req`, `cur_idx` and outputs `nxt`, `any_other`.
- Timer, FSM and lamp decode live in `tl_phase_scheduler`.

## Test plan
Defaults apply: N=4, MIN=8, MAX=32, Y=4, AR=2.
- Reset with `req`=0:
  - During reset, all lamps read `3'b100`.
  - Approach 0 is green 2 cycles after release and stays green for 100 cycles.
- `req`=4'b0100 from reset release: approach 0 is green for 8 cycles, yellow 4, all-red 2; approach 2 is green at cycle 16.
- Approach 0 green with `req`=4'b0011 held: approach 0 stays green for exactly 32 cycles (max), then approach 1 gets green.
- `req`=4'b1011 held with approach 0 green: the grant order is 1, 3, 0, 1, … (round-robin wrap-around).
- `req[1]` pulses for 1 cycle at green tmr=10, then drops: approach 1 still receives a green of at least 8 cycles.
- With `TL_PREEMPT_EN`: `preempt`=1, `preempt_idx`=3 at approach 0 green tmr=1 gives yellow next cycle; approach 3 is green 6 cycles later and held while `preempt`=1.
